// File: rtl/tlul_host_arb2.sv
// Two-to-one TL-UL host arbiter: round-robin (or fixed) A-channel grant with
// locking, D-channel return routing by source MSB, per-host outstanding limit.
package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_arb2
  import tlul_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          FixedPriority  = 1'b0
) (
  input  logic    clock,
  input  logic    reset,
  input  tl_h2d_t tl_h0_i,
  output tl_d2h_t tl_h0_o,
  input  tl_h2d_t tl_h1_i,
  output tl_d2h_t tl_h1_o,
  output tl_h2d_t tl_o,
  input  tl_d2h_t tl_i,
  output logic    busy_o,
  output logic    err_rsp_o
);
  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

  logic               lock, lock_idx, rr_last;
  logic [1:0][CW-1:0] cnt;
  logic [1:0]         elig, a_hs, d_hs, cnt_zero;
  logic               gnt_vld, gnt_idx, d_idx, a_fire, d_fire;
  tl_h2d_t            sel_req;

  assign elig[0] = tl_h0_i.a_valid && (cnt[0] < MaxCnt);
  assign elig[1] = tl_h1_i.a_valid && (cnt[1] < MaxCnt);

  // A held beat keeps its grant even if the host has since become ineligible.
  always_comb begin
    gnt_vld = 1'b1;
    gnt_idx = lock_idx;
    if (!lock) begin
      case (elig)
        2'b01:   gnt_idx = 1'b0;
        2'b10:   gnt_idx = 1'b1;
        2'b11:   gnt_idx = FixedPriority ? 1'b1 : !rr_last;
        default: begin
          gnt_vld = 1'b0;
          gnt_idx = 1'b0;
        end
      endcase
    end
  end

  assign sel_req = gnt_idx ? tl_h1_i : tl_h0_i;
  assign d_idx   = tl_i.d_source[TL_AIW-1];

  always_comb begin
    tl_o          = sel_req;
    tl_o.a_valid  = !reset && gnt_vld && sel_req.a_valid;
    tl_o.a_source = {gnt_idx, sel_req.a_source[TL_AIW-2:0]};
    tl_o.d_ready  = !reset && (d_idx ? tl_h1_i.d_ready : tl_h0_i.d_ready);
  end

  always_comb begin
    tl_h0_o                   = tl_i;
    tl_h0_o.d_source[TL_AIW-1] = 1'b0;
    tl_h0_o.d_valid           = !reset && tl_i.d_valid && !d_idx;
    tl_h0_o.a_ready           = !reset && gnt_vld && !gnt_idx && tl_i.a_ready;
    tl_h1_o                   = tl_i;
    tl_h1_o.d_source[TL_AIW-1] = 1'b0;
    tl_h1_o.d_valid           = !reset && tl_i.d_valid && d_idx;
    tl_h1_o.a_ready           = !reset && gnt_vld && gnt_idx && tl_i.a_ready;
  end

  assign a_fire   = tl_o.a_valid && tl_i.a_ready;
  assign d_fire   = tl_i.d_valid && tl_o.d_ready;
  assign a_hs     = {a_fire && gnt_idx, a_fire && !gnt_idx};
  assign d_hs     = {d_fire && d_idx, d_fire && !d_idx};
  assign cnt_zero = {cnt[1] == '0, cnt[0] == '0};

  always_ff @(posedge clock) begin
    if (reset) begin
      lock     <= 1'b0;
      lock_idx <= 1'b0;
      rr_last  <= 1'b1;
    end else if (a_fire) begin
      lock    <= 1'b0;
      rr_last <= gnt_idx;
    end else if (tl_o.a_valid) begin
      lock     <= 1'b1;
      lock_idx <= gnt_idx;
    end
  end

  // Simultaneous A and D handshakes for the same host cancel out.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (a_hs[i] && !d_hs[i])                     cnt[i] <= cnt[i] + 1'b1;
        else if (d_hs[i] && !a_hs[i] && !cnt_zero[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  assign busy_o    = !reset && (lock || !cnt_zero[0] || !cnt_zero[1]);
  assign err_rsp_o = |(d_hs & cnt_zero);
endmodule

// File: tb/tb_tlul_host_arb2.sv
// Directed bench for tlul_host_arb2: per-cycle vector table plus a lock
// stability sequence comparing the full merged A request.
module tb_tlul_host_arb2;
  import tlul_pkg::*;

  logic    clock = 1'b0;
  logic    reset;
  tl_h2d_t tl_h0_i, tl_h1_i, tl_o;
  tl_d2h_t tl_h0_o, tl_h1_o, tl_i;
  logic    busy_o, err_rsp_o;
  int      total = 0;
  int      bad = 0;

  always #5 clock = ~clock;

  tlul_host_arb2 dut (
    .clock     (clock),
    .reset     (reset),
    .tl_h0_i   (tl_h0_i),
    .tl_h0_o   (tl_h0_o),
    .tl_h1_i   (tl_h1_i),
    .tl_h1_o   (tl_h1_o),
    .tl_o      (tl_o),
    .tl_i      (tl_i),
    .busy_o    (busy_o),
    .err_rsp_o (err_rsp_o)
  );

  typedef struct {
    logic       rst, av0, av1, ar, dv, dr0, dr1;
    logic [7:0] dsrc;
    logic       e_av, e_ar0, e_ar1, e_dv0, e_dv1;
    logic [7:0] e_src, e_dsrc;
    logic       e_dr, e_busy, e_err;
  } vec_t;

  vec_t vecs[35];

  function automatic vec_t mk(input logic [6:0] in, input logic [7:0] dsrc,
                              input logic [4:0] oa, input logic [7:0] src,
                              input logic [7:0] edsrc, input logic [2:0] ob);
    vec_t v;
    {v.rst, v.av0, v.av1, v.ar, v.dv, v.dr0, v.dr1} = in;
    v.dsrc = dsrc;
    {v.e_av, v.e_ar0, v.e_ar1, v.e_dv0, v.e_dv1} = oa;
    v.e_src  = src;
    v.e_dsrc = edsrc;
    {v.e_dr, v.e_busy, v.e_err} = ob;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    tl_h2d_t exp_a;
    // inputs {rst av0 av1 ar dv dr0 dr1}, d_source | {a_valid ar0 ar1 dv0 dv1},
    // tl_o a_source, routed d_source | {tl_o d_ready, busy, err}
    vecs[0]  = mk(7'b1111111, 8'h03, 5'b00000, 8'h00, 8'h00, 3'b000);
    vecs[1]  = mk(7'b0101011, 8'h00, 5'b11000, 8'h03, 8'h00, 3'b100);
    vecs[2]  = mk(7'b0001101, 8'h03, 5'b00010, 8'h00, 8'h03, 3'b010);
    vecs[3]  = mk(7'b0001111, 8'h03, 5'b00010, 8'h00, 8'h03, 3'b110);
    vecs[4]  = mk(7'b1111011, 8'h00, 5'b00000, 8'h00, 8'h00, 3'b000);
    vecs[5]  = mk(7'b0111011, 8'h00, 5'b11000, 8'h03, 8'h00, 3'b100);
    vecs[6]  = mk(7'b0111011, 8'h00, 5'b10100, 8'h87, 8'h00, 3'b110);
    vecs[7]  = mk(7'b0111011, 8'h00, 5'b11000, 8'h03, 8'h00, 3'b110);
    vecs[8]  = mk(7'b0111011, 8'h00, 5'b10100, 8'h87, 8'h00, 3'b110);
    vecs[9]  = mk(7'b0111111, 8'h03, 5'b00010, 8'h00, 8'h03, 3'b110);
    vecs[10] = mk(7'b0111111, 8'h87, 5'b11001, 8'h03, 8'h07, 3'b110);
    vecs[11] = mk(7'b0001111, 8'h03, 5'b00010, 8'h00, 8'h03, 3'b110);
    vecs[12] = mk(7'b0001111, 8'h03, 5'b00010, 8'h00, 8'h03, 3'b110);
    vecs[13] = mk(7'b0001111, 8'h87, 5'b00001, 8'h00, 8'h07, 3'b110);
    vecs[14] = mk(7'b0110011, 8'h00, 5'b10000, 8'h87, 8'h00, 3'b100);
    vecs[15] = mk(7'b0110011, 8'h00, 5'b10000, 8'h87, 8'h00, 3'b110);
    vecs[16] = mk(7'b0110011, 8'h00, 5'b10000, 8'h87, 8'h00, 3'b110);
    vecs[17] = mk(7'b0111011, 8'h00, 5'b10100, 8'h87, 8'h00, 3'b110);
    vecs[18] = mk(7'b0111011, 8'h00, 5'b11000, 8'h03, 8'h00, 3'b110);
    vecs[19] = mk(7'b0011011, 8'h00, 5'b10100, 8'h87, 8'h00, 3'b110);
    vecs[20] = mk(7'b0111011, 8'h00, 5'b11000, 8'h03, 8'h00, 3'b110);
    vecs[21] = mk(7'b0111111, 8'h80, 5'b00001, 8'h00, 8'h00, 3'b110);
    vecs[22] = mk(7'b0111011, 8'h00, 5'b10100, 8'h87, 8'h00, 3'b110);
    vecs[23] = mk(7'b0001111, 8'h80, 5'b00001, 8'h00, 8'h00, 3'b110);
    vecs[24] = mk(7'b0001111, 8'h80, 5'b00001, 8'h00, 8'h00, 3'b110);
    vecs[25] = mk(7'b0001111, 8'h03, 5'b00010, 8'h00, 8'h03, 3'b110);
    vecs[26] = mk(7'b0001111, 8'h03, 5'b00010, 8'h00, 8'h03, 3'b110);
    vecs[27] = mk(7'b0001111, 8'h80, 5'b00001, 8'h00, 8'h00, 3'b101);
    vecs[28] = mk(7'b0001011, 8'h00, 5'b00000, 8'h00, 8'h00, 3'b100);
    vecs[29] = mk(7'b0011011, 8'h00, 5'b10100, 8'h87, 8'h00, 3'b100);
    vecs[30] = mk(7'b0110011, 8'h00, 5'b10000, 8'h03, 8'h00, 3'b110);
    vecs[31] = mk(7'b1111011, 8'h00, 5'b00000, 8'h00, 8'h00, 3'b000);
    vecs[32] = mk(7'b0010111, 8'h87, 5'b10001, 8'h87, 8'h07, 3'b101);
    vecs[33] = mk(7'b0011011, 8'h00, 5'b10100, 8'h87, 8'h00, 3'b110);
    vecs[34] = mk(7'b0001011, 8'h00, 5'b00000, 8'h00, 8'h00, 3'b110);

    tl_h0_i = '0;
    tl_h0_i.a_opcode  = Get;
    tl_h0_i.a_size    = 2'd2;
    tl_h0_i.a_source  = 8'h03;
    tl_h0_i.a_address = 32'h1000;
    tl_h0_i.a_mask    = 4'hf;
    tl_h1_i = '0;
    tl_h1_i.a_opcode  = PutFullData;
    tl_h1_i.a_size    = 2'd2;
    tl_h1_i.a_source  = 8'h07;
    tl_h1_i.a_address = 32'h2000;
    tl_h1_i.a_mask    = 4'hf;
    tl_h1_i.a_data    = 32'h5555_AAAA;
    tl_i = '0;
    tl_i.d_opcode = AccessAckData;
    tl_i.d_size   = 2'd2;
    tl_i.d_data   = 32'hCAFE_F00D;
    reset = 1'b1;
    repeat (2) @(posedge clock);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(posedge clock);
      #1;
      reset           = v.rst;
      tl_h0_i.a_valid = v.av0;
      tl_h1_i.a_valid = v.av1;
      tl_h0_i.d_ready = v.dr0;
      tl_h1_i.d_ready = v.dr1;
      tl_i.a_ready    = v.ar;
      tl_i.d_valid    = v.dv;
      tl_i.d_source   = v.dsrc;
      #4;
      chk("a_valid", i, 128'(tl_o.a_valid), 128'(v.e_av));
      chk("h0_a_ready", i, 128'(tl_h0_o.a_ready), 128'(v.e_ar0));
      chk("h1_a_ready", i, 128'(tl_h1_o.a_ready), 128'(v.e_ar1));
      chk("h0_d_valid", i, 128'(tl_h0_o.d_valid), 128'(v.e_dv0));
      chk("h1_d_valid", i, 128'(tl_h1_o.d_valid), 128'(v.e_dv1));
      chk("d_ready", i, 128'(tl_o.d_ready), 128'(v.e_dr));
      chk("busy", i, 128'(busy_o), 128'(v.e_busy));
      chk("err_rsp", i, 128'(err_rsp_o), 128'(v.e_err));
      if (v.e_av) begin
        chk("a_source", i, 128'(tl_o.a_source), 128'(v.e_src));
        chk("a_address", i, 128'(tl_o.a_address),
            v.e_src[7] ? 128'h2000 : 128'h1000);
      end
      if (v.e_dv0) begin
        chk("h0_d_source", i, 128'(tl_h0_o.d_source), 128'(v.e_dsrc));
        chk("h0_d_data", i, 128'(tl_h0_o.d_data), 128'hCAFE_F00D);
      end
      if (v.e_dv1) begin
        chk("h1_d_source", i, 128'(tl_h1_o.d_source), 128'(v.e_dsrc));
        chk("h1_d_data", i, 128'(tl_h1_o.d_data), 128'hCAFE_F00D);
      end
    end

    // Locked beat must present identical A fields until accepted, then rotate.
    @(posedge clock);
    #1;
    reset = 1'b1;
    tl_i.d_valid  = 1'b0;
    tl_i.d_source = 8'h00;
    tl_h0_i.a_data = 32'h1111_1111;
    tl_h1_i.a_data = 32'h2222_2222;
    tl_h0_i.d_ready = 1'b1;
    tl_h1_i.d_ready = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    tl_h0_i.a_valid = 1'b1;
    tl_h1_i.a_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin
        @(posedge clock);
        #1;
      end
      tl_i.a_ready = (k == 3);
      #4;
      exp_a = tl_h0_i;
      chk("lock_a_fields", 100 + k, 128'(tl_o), 128'(exp_a));
      chk("lock_h0_a_ready", 100 + k, 128'(tl_h0_o.a_ready), 128'(k == 3));
      chk("lock_h1_a_ready", 100 + k, 128'(tl_h1_o.a_ready), 128'h0);
    end
    @(posedge clock);
    #5;
    exp_a = tl_h1_i;
    exp_a.a_source = 8'h87;
    chk("rotate_a_fields", 104, 128'(tl_o), 128'(exp_a));
    chk("rotate_h1_a_ready", 104, 128'(tl_h1_o.a_ready), 128'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tlul_host_arb2.md
# tlul_host_arb2

Two-to-one TL-UL host arbiter. It merges two TL-UL host ports onto a single TL-UL host port toward the crossbar or device: port 0 is the core's instruction adapter and port 1 is the data adapter.
- A-channel: round-robin arbitration with grant locking.
- D-channel: responses are routed back by tagging the MSB of `a_source`.
- Each host has a bounded count of outstanding requests.

The block sits between the core's two `tlul_adapter_host` instances and the SoC crossbar. It lets a single-port core variant share one bus slot.

## Interface
Parameters:
- `MaxOutstanding`, default 2: maximum in-flight requests per host. Valid range is 1..15.
- `FixedPriority`, default 1'b0: when set, host 1 (data) always wins contention; when clear, arbitration is round-robin.

Ports:
- `clock` in 1: single clock; every register is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `tl_h0_i` in `tlul_pkg::tl_h2d_t`: host 0 request (instruction).
- `tl_h0_o` out `tlul_pkg::tl_d2h_t`: host 0 response.
- `tl_h1_i` in `tlul_pkg::tl_h2d_t`: host 1 request (data).
- `tl_h1_o` out `tlul_pkg::tl_d2h_t`: host 1 response.
- `tl_o` out `tlul_pkg::tl_h2d_t`: merged request toward the device.
- `tl_i` in `tlul_pkg::tl_d2h_t`: response from the device.
- `busy_o` out 1: high when any request is outstanding or the grant is locked.
- `err_rsp_o` out 1: one-cycle pulse when a D beat arrives for a host whose outstanding count is 0.

## Operation
Registered state:
- `lock`: 1 bit.
- `lock_idx`: 1 bit.
- `rr_last`: 1 bit, the host last granted.
- `cnt0` and `cnt1`: outstanding counters, each `$clog2(MaxOutstanding+1)` bits.

Eligibility:
- Host n is eligible when `tl_hn_i.a_valid` is high and `cntn < MaxOutstanding`.

Grant selection, in order of precedence:
- If `lock` is set, the grant is `lock_idx`, regardless of eligibility.
- Otherwise, if only one host is eligible, that host is granted.
- Otherwise, if both are eligible, the winner is host 1 when `FixedPriority`=1, or `!rr_last` when `FixedPriority`=0.
- Otherwise there is no grant and `tl_o.a_valid` = 0.

A-channel forwarding:
- All A fields of the granted host are forwarded combinationally to `tl_o`.
- `a_source` is replaced by `{grant_idx, host a_source[TL_AIW-2:0]}`.
- Hosts must drive `a_source` MSB = 0; the block overwrites it without checking.
- The granted host's `a_ready` is `tl_i.a_ready`. The other host's `a_ready` is 0.

Locking:
- When grant is active, `a_valid` is high and `a_ready` is low, set `lock`=1 and `lock_idx`=grant. This satisfies the TL-UL rule that a valid A beat must stay stable until accepted.
- On the A handshake, clear `lock` and set `rr_last`=grant.

D-channel routing:
- `idx` = `tl_i.d_source[TL_AIW-1]`.
- `tl_h<idx>_o` carries all D fields with `d_source` MSB cleared, and `d_valid` = `tl_i.d_valid`.
- The other host's `d_valid` is 0.
- `tl_o.d_ready` = `tl_h<idx>_i.d_ready`.

Counters:
- `cntn` increments on an A handshake for host n and decrements on a D handshake for host n.
- When both occur in the same cycle, the count is unchanged.
- A decrement when the count is 0 saturates at 0 and pulses `err_rsp_o`. The beat is still forwarded.
- An increment can never exceed `MaxOutstanding`, because a host at the limit is ineligible. A locked request was already eligible when the lock was set.

## Timing
- Zero-cycle combinational latency on both the A path (host to `tl_o`) and the D path (`tl_i` to host). The block adds no pipeline stages.
- The grant changes only when the lock is clear. Round-robin alternates on every accepted beat under continuous contention.
- Registered state updates at the clock edge after the handshake. Eligibility in cycle N uses counters as of the end of cycle N-1.
- Reset values: `lock`=0, `lock_idx`=0, `rr_last`=1 (so host 0 wins the first contention), counters 0, `err_rsp_o`=0, `busy_o`=0.
- While `reset` is high, the following outputs are forced low: `tl_o.a_valid`, both hosts' `a_ready`, both hosts' `d_valid`, and `tl_o.d_ready`.
- Reset in mid-transaction discards all state. In-flight responses arriving after reset are routed by source bit. If the target counter is 0, they pulse `err_rsp_o`.
- An A handshake and a D handshake for different hosts in the same cycle update the two counters independently.

## Test plan
- Single host: host 0 issues a Get to 0x1000 with source 0x03. Expect `tl_o.a_source`=0x03. The device returns `d_source`=0x03 with data 0xCAFEF00D. Expect host 0 to receive `d_source`=0x03 and the data, and host 1 to see `d_valid`=0.
- Contention, round-robin: both hosts hold `a_valid` with device `a_ready`=1 for 4 cycles. Expect grants 0,1,0,1. Host 1 beats carry `a_source` MSB=1.
- Lock: both valid, device `a_ready`=0 for 3 cycles, then 1. Expect the grant to stay on the first winner and `tl_o` A fields to be stable for all 4 cycles. The other host is granted next.
- Outstanding limit (`MaxOutstanding`=2): host 1 issues 2 Puts with no responses. Expect the third request to be held off with `a_ready`=0 while host 0 is still granted. After one `AccessAck` to host 1, expect host 1's next request to be accepted in the following cycle.
- Simultaneous events: host 0 A handshake and host 1 D handshake in the same cycle. Expect `cnt0`+1, `cnt1`-1, and `busy_o` consistent.
- Error and reset: a D beat with `d_source`=0x80 while `cnt1`=0. Expect a one-cycle `err_rsp_o` pulse and the beat delivered to host 1. Then assert `reset` for 1 cycle mid-lock. Expect `lock` cleared, counters at 0, and `tl_o.a_valid`=0 during reset.
